// File: rtl/pds_port_router.sv
// Packet router: demultiplexes one ingress packet stream by target field into
// NUM_PORTS show-ahead egress FIFOs with valid/ready handshakes and a drop counter.
module pds_port_router #(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DROP_ON_FULL = 1,
  parameter int CNT_W        = 16,
  localparam int PKT_W       = 2*ADDR_W + DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PKT_W-1:0]           data_ip,
  input  logic                       valid_up,
  output logic                       ready_up,
  output logic [NUM_PORTS*PKT_W-1:0] data_op,
  output logic [NUM_PORTS-1:0]       valid_op,
  input  logic [NUM_PORTS-1:0]       ready_op,
  output logic [NUM_PORTS-1:0]       fifo_full,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ADDR_W-1:0]    target;
  logic [NUM_PORTS-1:0] sel;
  logic                 target_valid;
  logic                 target_full;
  logic                 accept;
  logic                 drop;
  logic [CNT_W-1:0]     drop_cnt_reg;

  assign target       = data_ip[DATA_W +: ADDR_W];
  // One-hot port select; an all-zero vector means the target is out of range.
  assign target_valid = |sel;
  assign target_full  = |(sel & fifo_full);

  always_comb begin
    ready_up = 1'b0;
    if (reset) begin
      if (DROP_ON_FULL != 0) ready_up = 1'b1;
      else                   ready_up = !target_full;
    end
  end

  assign accept   = valid_up && ready_up;
  assign drop     = accept && (!target_valid || target_full);
  assign drop_cnt = drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != {CNT_W{1'b1}})) begin
      drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [PKT_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [PTR_W:0]   count_reg;
      logic [PTR_W:0]   count_next;
      logic             full_reg;
      logic             push;
      logic             pop;
      logic             not_empty;

      assign sel[gi]   = (target == ADDR_W'(gi));
      assign not_empty = (count_reg != '0);
      // Full is the start-of-cycle state, so a same-cycle pop does not make room.
      assign push      = accept && sel[gi] && !full_reg;
      assign pop       = not_empty && ready_op[gi];

      always_comb begin
        count_next = count_reg;
        case ({push, pop})
          2'b10:   count_next = count_reg + (PTR_W+1)'(1);
          2'b01:   count_next = count_reg - (PTR_W+1)'(1);
          default: count_next = count_reg;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          full_reg   <= 1'b0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          count_reg <= count_next;
          full_reg  <= (count_next == (PTR_W+1)'(FIFO_DEPTH));
        end
      end

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= data_ip;
      end

      assign valid_op[gi]                 = not_empty;
      assign fifo_full[gi]                = full_reg;
      assign data_op[gi*PKT_W +: PKT_W]   = not_empty ? mem[rd_ptr_reg] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_pds_port_router.sv
// Directed bench for pds_port_router: one dropping instance and one stalling
// instance, checked with immediate assertions against hand-computed values.
module tb_pds_port_router;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_ip;
  logic        valid_up;
  logic        ready_up;
  logic [63:0] data_op;
  logic [3:0]  valid_op;
  logic [3:0]  ready_op;
  logic [3:0]  fifo_full;
  logic [15:0] drop_cnt;

  logic [15:0] s_data_ip;
  logic        s_valid_up;
  logic        s_ready_up;
  logic [63:0] s_data_op;
  logic [3:0]  s_valid_op;
  logic [3:0]  s_ready_op;
  logic [3:0]  s_fifo_full;
  logic [15:0] s_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pds_port_router #(.NUM_PORTS(4), .ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4),
                    .DROP_ON_FULL(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .data_ip(data_ip), .valid_up(valid_up),
    .ready_up(ready_up), .data_op(data_op), .valid_op(valid_op),
    .ready_op(ready_op), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
  );

  pds_port_router #(.NUM_PORTS(4), .ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4),
                    .DROP_ON_FULL(0), .CNT_W(16)) dut_stall (
    .clk(clk), .reset(reset), .data_ip(s_data_ip), .valid_up(s_valid_up),
    .ready_up(s_ready_up), .data_op(s_data_op), .valid_op(s_valid_op),
    .ready_op(s_ready_op), .fifo_full(s_fifo_full), .drop_cnt(s_drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s: observed %h expected %h ok", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    valid_up   = 1'b1;
    data_ip    = 16'h12A5;
    ready_op   = 4'hF;
    s_valid_up = 1'b0;
    s_data_ip  = 16'h0000;
    s_ready_op = 4'h0;

    // 1: reset with valid ingress
    step();
    step();
    check("rst_valid_op", 64'(valid_op), 64'h0);
    check("rst_data_op", data_op, 64'h0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    check("rst_fifo_full", 64'(fifo_full), 64'h0);
    check("rst_ready_up", 64'(ready_up), 64'h0);
    reset    = 1'b1;
    valid_up = 1'b0;
    step();
    check("post_rst_valid_op", 64'(valid_op), 64'h0);

    // 2: single packet to port 2
    data_ip  = 16'h12A5;
    valid_up = 1'b1;
    #1;
    check("t2_ready_up", 64'(ready_up), 64'h1);
    step();
    valid_up = 1'b0;
    check("t2_valid_op", 64'(valid_op), 64'h4);
    check("t2_data_op", data_op, 64'h0000_12A5_0000_0000);
    step();
    check("t2_popped", 64'(valid_op), 64'h0);

    // 3: fill port 0, drop the fifth, drain in order
    ready_op = 4'h0;
    for (int i = 1; i <= 5; i++) begin
      data_ip  = 16'h1000 + 16'(i);
      valid_up = 1'b1;
      step();
      if (i == 4) check("t3_full_after4", 64'(fifo_full), 64'h1);
    end
    valid_up = 1'b0;
    check("t3_drop_cnt", 64'(drop_cnt), 64'h1);
    ready_op = 4'h1;
    for (int k = 1; k <= 4; k++) begin
      check("t3_valid0", 64'(valid_op[0]), 64'h1);
      check("t3_head0", 64'(data_op[15:0]), 64'h1000 + 64'(k));
      step();
    end
    check("t3_drained", 64'(valid_op), 64'h0);
    check("t3_full_clear", 64'(fifo_full), 64'h0);

    // 4: stalling instance
    for (int i = 1; i <= 4; i++) begin
      s_data_ip  = 16'h1000 + 16'(i);
      s_valid_up = 1'b1;
      step();
    end
    check("t4_full0", 64'(s_fifo_full), 64'h1);
    s_data_ip = 16'h10FF;
    #1;
    check("t4_stall", 64'(s_ready_up), 64'h0);
    step();
    check("t4_no_drop", 64'(s_drop_cnt), 64'h0);
    check("t4_head_kept", 64'(s_data_op[15:0]), 64'h1001);
    s_data_ip = 16'h11EE;
    #1;
    check("t4_ready_port1", 64'(s_ready_up), 64'h1);
    step();
    check("t4_valid_port1", 64'(s_valid_op), 64'h3);
    check("t4_data_port1", 64'(s_data_op[31:16]), 64'h11EE);
    s_data_ip  = 16'h10FF;
    s_ready_op = 4'h1;
    #1;
    check("t4_still_stalled", 64'(s_ready_up), 64'h0);
    step();
    check("t4_unstalled", 64'(s_ready_up), 64'h1);
    step();
    s_valid_up = 1'b0;
    check("t4_head_after_accept", 64'(s_data_op[15:0]), 64'h1003);
    step();
    step();
    check("t4_accepted_pkt", 64'(s_data_op[15:0]), 64'h10FF);
    check("t4_drop_cnt_final", 64'(s_drop_cnt), 64'h0);
    s_ready_op = 4'hF;
    step();

    // 5: invalid target dropped
    data_ip  = 16'h17AA;
    valid_up = 1'b1;
    #1;
    check("t5_ready_up", 64'(ready_up), 64'h1);
    step();
    valid_up = 1'b0;
    check("t5_no_valid", 64'(valid_op), 64'h0);
    check("t5_drop_cnt", 64'(drop_cnt), 64'h2);

    // 6: port 3 full, push+pop same cycle drops the push
    ready_op = 4'h0;
    for (int i = 0; i < 4; i++) begin
      data_ip  = 16'h1330 + 16'(i);
      valid_up = 1'b1;
      step();
    end
    check("t6_full3", 64'(fifo_full), 64'h8);
    data_ip  = 16'h13F0;
    ready_op = 4'h8;
    step();
    valid_up = 1'b0;
    ready_op = 4'h0;
    check("t6_drop_cnt", 64'(drop_cnt), 64'h3);
    check("t6_not_full", 64'(fifo_full), 64'h0);
    check("t6_head3", 64'(data_op[63:48]), 64'h1331);
    ready_op = 4'h8;
    step();
    ready_op = 4'h0;
    check("t6_head3_b", 64'(data_op[63:48]), 64'h1332);
    ready_op = 4'h8;
    step();
    ready_op = 4'h0;
    check("t6_head3_c", 64'(data_op[63:48]), 64'h1333);
    reset = 1'b0;
    step();
    check("t6_rst_valid_op", 64'(valid_op), 64'h0);
    check("t6_rst_data_op", data_op, 64'h0);
    reset = 1'b1;
    step();
    check("t6_empty_after_rst", 64'(valid_op), 64'h0);
    check("t6_drop_cnt_rst", 64'(drop_cnt), 64'h0);
    data_ip  = 16'h1301;
    valid_up = 1'b1;
    step();
    valid_up = 1'b0;
    check("t6_fresh_head", 64'(data_op[63:48]), 64'h1301);
    check("t6_fresh_valid", 64'(valid_op), 64'h8);
    ready_op = 4'hF;
    step();

    // 5 (cont.): saturation of the drop counter
    data_ip  = 16'h17AA;
    valid_up = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("sat_reach", 64'(drop_cnt), 64'hFFFF);
    step();
    step();
    step();
    valid_up = 1'b0;
    check("sat_hold", 64'(drop_cnt), 64'hFFFF);
    check("sat_no_valid", 64'(valid_op), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
